parity_frame_checker: RTL and testbench

//  Streaming parity checker, downstream of the 4-input XOR parity stage.
//  - Accepts 4-bit nibbles over a valid/ready handshake.
//  - Folds each nibble's XOR parity into a running frame parity over FRAME_LEN nibbles.
//  - Compares the result with the expected parity bit sent on the frame's last nibble.
//  - Emits one result per frame over a valid/ready output handshake.

---
 rtl/parity_frame_checker_if.sv | 22 ++
 rtl/parity_frame_checker.sv | 106 ++++++++++
 tb/tb_parity_frame_checker.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parity_frame_checker_if.sv
// Handshake bundle for parity_frame_checker: nibble input stream
// and per-frame result stream, each with valid/ready.
interface parity_frame_checker_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_par;
    logic       out_valid;
    logic       out_ready;
    logic       out_parity;
    logic       out_err;

    modport master (
        output in_valid, in_data, in_par, out_ready,
        input  in_ready, out_valid, out_parity, out_err
    );

    modport slave (
        input  in_valid, in_data, in_par, out_ready,
        output in_ready, out_valid, out_parity, out_err
    );
endinterface

// File: rtl/parity_frame_checker.sv
// Streaming frame parity checker over FRAME_LEN nibbles per frame.
// Define PFC_ERR_COUNT_EN to add the saturating err_count output.
module parity_frame_checker #(
    parameter int FRAME_LEN  = 4,
    parameter int ODD_PARITY = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    parity_frame_checker_if.slave  bus
`ifdef PFC_ERR_COUNT_EN
    ,
    output logic [7:0]             err_count
`endif
);
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
    localparam logic ODD = (ODD_PARITY != 0);

    typedef enum logic {ACCUM, RESULT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          acc_q, acc_d;
    logic          rdy_q, rdy_d;
    logic          vld_q, vld_d;
    logic          par_q, par_d;
    logic          err_q, err_d;
    logic          in_beat, out_beat, nib, p;

    assign in_beat  = bus.in_valid & rdy_q;
    assign out_beat = vld_q & bus.out_ready;
    assign nib      = ^bus.in_data;
    assign p        = acc_q ^ nib ^ ODD;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            par_q   <= par_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rdy_d   = rdy_q;
        vld_d   = vld_q;
        par_d   = par_q;
        err_d   = err_q;
        unique case (state_q)
            ACCUM: begin
                if (in_beat) begin
                    if (cnt_q == LAST) begin
                        par_d   = p;
                        err_d   = (p != bus.in_par);
                        acc_d   = 1'b0;
                        cnt_d   = '0;
                        rdy_d   = 1'b0;
                        vld_d   = 1'b1;
                        state_d = RESULT;
                    end else begin
                        acc_d = acc_q ^ nib;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            RESULT: begin
                // Result stays frozen until the consumer takes it.
                if (out_beat) begin
                    vld_d   = 1'b0;
                    rdy_d   = 1'b1;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    assign bus.in_ready   = rdy_q;
    assign bus.out_valid  = vld_q;
    assign bus.out_parity = par_q;
    assign bus.out_err    = err_q;

`ifdef PFC_ERR_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= 8'd0;
        end else if (out_beat && err_q && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_parity_frame_checker.sv
// Randomised self-checking bench for parity_frame_checker; a second
// instance with ODD_PARITY=1 shadows the same stimulus.
module tb_parity_frame_checker;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    parity_frame_checker_if bus ();
    parity_frame_checker_if odd ();

    assign odd.in_valid  = bus.in_valid;
    assign odd.in_data   = bus.in_data;
    assign odd.in_par    = bus.in_par;
    assign odd.out_ready = bus.out_ready;

`ifdef PFC_ERR_COUNT_EN
    logic [7:0] ec, ec_odd;
`endif

    parity_frame_checker #(.FRAME_LEN(4), .ODD_PARITY(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef PFC_ERR_COUNT_EN
        ,
        .err_count (ec)
`endif
    );

    parity_frame_checker #(.FRAME_LEN(4), .ODD_PARITY(1)) dut_odd (
        .clk   (clk),
        .reset (reset),
        .bus   (odd)
`ifdef PFC_ERR_COUNT_EN
        ,
        .err_count (ec_odd)
`endif
    );

    typedef logic [3:0] frame_t [4];

    // Frame parity = parity of total set bits across all nibbles.
    function automatic logic ref_par(input frame_t f, input logic o);
        int c = 0;
        foreach (f[i]) c += $countones(f[i]);
        return logic'(c % 2) ^ o;
    endfunction

    task automatic put(input logic [3:0] d, input logic p);
        int t = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_par   = p;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (t >= 50) begin
            miscompares++;
            $display("FAIL put_timeout in_ready got %b want 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input frame_t f, input logic par, input int gap);
        for (int i = 0; i < 4; i++) begin
            repeat (gap) @(negedge clk);
            put(f[i], (i == 3) ? par : 1'($urandom));
        end
    endtask

    task automatic check_result(input string name, input frame_t f,
                                input logic par, input int dly);
        logic ep, eo;
        ep = ref_par(f, 1'b0);
        eo = ref_par(f, 1'b1);
        vectors++;
        if (bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s out_valid got %b want 1", name, bus.out_valid);
        end
        vectors++;
        if (bus.out_parity !== ep) begin
            miscompares++;
            $display("FAIL %s out_parity got %b want %b", name, bus.out_parity, ep);
        end
        vectors++;
        if (bus.out_err !== (ep != par)) begin
            miscompares++;
            $display("FAIL %s out_err got %b want %b", name, bus.out_err, ep != par);
        end
        vectors++;
        if (odd.out_parity !== eo || odd.out_err !== (eo != par)) begin
            miscompares++;
            $display("FAIL %s odd par/err got %b%b want %b%b", name,
                     odd.out_parity, odd.out_err, eo, eo != par);
        end
        repeat (dly) @(negedge clk);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s post_ack valid/ready got %b%b want 01", name,
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({bus.in_ready, bus.out_valid, bus.out_parity, bus.out_err} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset rdy/vld/par/err got %b%b%b%b want 1000",
                     bus.in_ready, bus.out_valid, bus.out_parity, bus.out_err);
        end
`ifdef PFC_ERR_COUNT_EN
        vectors++;
        if (ec !== 8'd0) begin
            miscompares++;
            $display("FAIL reset err_count got %0d want 0", ec);
        end
`endif
    endtask

    task automatic test_clean();
        frame_t f = '{4'b0001, 4'b0011, 4'b0000, 4'b1111};
        send_frame(f, 1'b1, 0);
        check_result("clean", f, 1'b1, 0);
        send_frame(f, 1'b0, 0);
        check_result("bad_par", f, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        frame_t f = '{4'b0001, 4'b0011, 4'b0000, 4'b1111};
        frame_t g = '{4'b1000, 4'b0000, 4'b0000, 4'b0000};
        send_frame(f, 1'b1, 0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b1000;
        bus.in_par   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.out_valid, bus.out_parity, bus.out_err, bus.in_ready} !== 4'b1100) begin
                miscompares++;
                $display("FAIL stall vld/par/err/rdy got %b%b%b%b want 1100",
                         bus.out_valid, bus.out_parity, bus.out_err, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_ack valid/ready got %b%b want 01",
                     bus.out_valid, bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_first in_ready got %b want 1", bus.in_ready);
        end
        put(4'b0000, 1'b0);
        put(4'b0000, 1'b0);
        put(4'b0000, 1'b1);
        check_result("after_stall", g, 1'b1, 0);
    endtask

    task automatic test_gapped();
        frame_t f = '{4'b0001, 4'b0011, 4'b0000, 4'b1111};
        send_frame(f, 1'b1, 3);
        check_result("gapped", f, 1'b1, 0);
    endtask

    task automatic test_reset_mid();
        frame_t f = '{4'b1000, 4'b0000, 4'b0000, 4'b0000};
        put(4'b0111, 1'b0);
        put(4'b0001, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b0111;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        send_frame(f, 1'b1, 0);
        check_result("reset_mid", f, 1'b1, 0);
        send_frame(f, 1'b0, 0);
        do_reset();
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_result valid/ready got %b%b want 01",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_random();
        frame_t f;
        logic   par;
        for (int n = 0; n < 40; n++) begin
            foreach (f[i]) f[i] = 4'($urandom);
            par = 1'($urandom);
            send_frame(f, par, int'($urandom_range(0, 2)));
            check_result("random", f, par, int'($urandom_range(0, 3)));
        end
    endtask

`ifdef PFC_ERR_COUNT_EN
    task automatic test_err_count();
        frame_t z = '{4'h0, 4'h0, 4'h0, 4'h0};
        int exp_n = 0;
        do_reset();
        for (int n = 0; n < 257; n++) begin
            send_frame(z, 1'b1, 0);
            @(negedge clk);
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            if (exp_n < 255) exp_n++;
        end
        vectors++;
        if (ec !== 8'(exp_n) || ec_odd !== 8'd0) begin
            miscompares++;
            $display("FAIL err_sat got %0d/%0d want %0d/0", ec, ec_odd, exp_n);
        end
        do_reset();
        vectors++;
        if (ec !== 8'd0) begin
            miscompares++;
            $display("FAIL err_clear got %0d want 0", ec);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'h0;
        bus.in_par    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_clean();
        test_backpressure();
        test_gapped();
        test_reset_mid();
        test_random();
`ifdef PFC_ERR_COUNT_EN
        test_err_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
